// File: rtl/axis_fifo_wr_arb.sv
// Round-robin arbiter merging NCH AXI-Stream sources into one native FIFO
// write port, granting up to BURST beats per channel before moving on.
module axis_fifo_wr_arb #(
  parameter int DW    = 24,
  parameter int NCH   = 4,
  parameter int BURST = 8,
  localparam int CW   = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH*DW-1:0] s_axis_tdata,
  input  logic [NCH-1:0]    s_axis_tvalid,
  output logic [NCH-1:0]    s_axis_tready,
  input  logic [NCH-1:0]    ch_en,
  output logic [CW+DW-1:0]  fifo_din,
  output logic              fifo_wr,
  input  logic              fifo_full,
  output logic [CW-1:0]     grant_ch,
  output logic              busy,
  output logic [31:0]       word_cnt
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t            state;
  logic [CW-1:0]     rr_ptr;
  logic [CW-1:0]     cur_ch;
  logic [7:0]        beat_cnt;
  logic [CW+DW-1:0]  din_q;

  logic [NCH-1:0]    req;
  logic              in_grant;
  logic              cur_vld;
  logic              cur_en;
  logic [DW-1:0]     cur_data;
  logic              rdy;
  logic              xfer;
  logic              last_beat;
  logic              rel;
  logic              pick_vld;
  logic [CW-1:0]     pick;

  assign req       = s_axis_tvalid & ch_en;
  assign in_grant  = (state == GRANT);
  assign cur_vld   = s_axis_tvalid[cur_ch];
  assign cur_en    = ch_en[cur_ch];
  assign cur_data  = s_axis_tdata[int'(cur_ch)*DW +: DW];
  assign rdy       = rst_n & in_grant & cur_en & ~fifo_full;
  assign xfer      = rdy & cur_vld;
  assign last_beat = (beat_cnt == 8'(BURST-1));
  assign rel       = (xfer & last_beat) | ~cur_vld | ~cur_en;

  assign fifo_wr   = xfer;
  assign busy      = rst_n & in_grant;
  assign grant_ch  = rst_n ? cur_ch : '0;
  assign fifo_din  = in_grant ? {cur_ch, cur_data} : din_q;

  always_comb begin
    s_axis_tready         = '0;
    s_axis_tready[cur_ch] = rdy;
  end

  // First requester at or after rr_ptr; NCH is a power of 2 so the sum wraps
  always_comb begin
    logic [CW-1:0] idx;
    pick_vld = 1'b0;
    pick     = '0;
    idx      = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = rr_ptr + CW'(k);
      if (!pick_vld && req[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      cur_ch   <= '0;
      beat_cnt <= '0;
      word_cnt <= '0;
      din_q    <= '0;
    end else begin
      if (in_grant)
        din_q <= {cur_ch, cur_data};
      if (xfer)
        word_cnt <= word_cnt + 32'd1;
      unique case (state)
        IDLE: begin
          if (pick_vld) begin
            cur_ch   <= pick;
            beat_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (xfer)
            beat_cnt <= beat_cnt + 8'd1;
          if (rel) begin
            rr_ptr <= cur_ch + CW'(1);
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axis_fifo_wr_arb.md
AXIS_FIFO_WR_ARB -- requirements
Module: axis_fifo_wr_arb

Interface
REQ-001 The block SHALL have parameter DW, default 24, meaning sample width per AXIS channel.
REQ-002 The block SHALL have parameter NCH, default 4, meaning number of AXIS sources (power of 2, 2..8); CW = log2(NCH).
REQ-003 The block SHALL have parameter BURST, default 8, meaning maximum beats per grant (1..255).
REQ-004 The block SHALL have port clk  input  1  meaning single clock; all logic on the rising edge.
REQ-005 The block SHALL have port rst_n  input  1  meaning reset, synchronous and active-low.
REQ-006 The block SHALL have port s_axis_tdata  input  NCH*DW  meaning channel i data at bits [i*DW +: DW].
REQ-007 The block SHALL have port s_axis_tvalid  input  NCH  meaning per-channel valid.
REQ-008 The block SHALL have port s_axis_tready  output  NCH  meaning per-channel ready.
REQ-009 The block SHALL have port ch_en  input  NCH  meaning per-channel arbitration enable.
REQ-010 The block SHALL have port fifo_din  output  CW+DW  meaning {channel id, data} to the native FIFO.
REQ-011 The block SHALL have port fifo_wr  output  1  meaning native FIFO write strobe.
REQ-012 The block SHALL have port fifo_full  input  1  meaning native FIFO full flag.
REQ-013 The block SHALL have port grant_ch  output  CW  meaning currently or last granted channel.
REQ-014 The block SHALL have port busy  output  1  meaning high while in GRANT.
REQ-015 The block SHALL have port word_cnt  output  32  meaning total words written since reset.

Function
REQ-016 The block SHALL implement the two states IDLE and GRANT, plus registers rr_ptr (CW), cur_ch (CW) and beat_cnt (8 bits).
REQ-017 A requester SHALL be a channel i with s_axis_tvalid[i] & ch_en[i].
REQ-018 In IDLE with at least one requester, the block SHALL load cur_ch with the first requester searching rr_ptr, rr_ptr+1, ... mod NCH, clear beat_cnt and enter GRANT next cycle.
REQ-019 In IDLE, all s_axis_tready bits and fifo_wr SHALL be 0; with no requester the block SHALL stay in IDLE.
REQ-020 In GRANT, s_axis_tready[cur_ch] SHALL equal !fifo_full & ch_en[cur_ch], combinationally; all other ready bits SHALL be 0.
REQ-021 A transfer SHALL be tvalid[cur_ch] & tready[cur_ch] in GRANT; fifo_wr SHALL equal transfer, combinationally, with zero-cycle latency.
REQ-022 fifo_din SHALL equal {cur_ch, tdata of cur_ch} whenever in GRANT, and SHALL hold its last value in IDLE.
REQ-023 beat_cnt SHALL increment on each transfer.
REQ-024 GRANT SHALL release to IDLE on the first of these events: a transfer with beat_cnt == BURST-1; tvalid[cur_ch] low in a cycle; or ch_en[cur_ch] low.
REQ-025 On release, rr_ptr SHALL be set to (cur_ch+1) mod NCH; the pointer wraps from NCH-1 to 0.
REQ-026 When fifo_full is high with tvalid[cur_ch] high, the block SHALL hold GRANT, transfer nothing, and keep beat_cnt unchanged.
REQ-027 Channels with ch_en low SHALL never be granted and their tready SHALL stay 0.
REQ-028 word_cnt SHALL increment by 1 per fifo_wr and wrap from 0xFFFFFFFF to 0.
REQ-029 Sustained throughput per grant SHALL be BURST beats in BURST+1 cycles, because of the one-cycle IDLE arbitration bubble.

Reset
REQ-030 While rst_n is low at a clock edge, the block SHALL set state=IDLE, rr_ptr=0, cur_ch=0, beat_cnt=0, word_cnt=0 and fifo_din=0.
REQ-031 While rst_n is low, s_axis_tready, fifo_wr and busy SHALL be forced to 0 combinationally, and grant_ch SHALL read 0.
REQ-032 A reset asserted mid-burst SHALL abandon the burst with no write in the reset cycle, and arbitration SHALL restart from channel 0.

Verification
REQ-033 The bench SHALL cover: all 4 channels continuously valid, BURST=8 -> grants ch0,1,2,3,0 in order, 8 writes each, one idle cycle between, fifo_din[25:24] matches ch.
REQ-034 The bench SHALL cover: only ch2 valid, sending 3 words then dropping valid -> 3 writes, release, rr_ptr=3, word_cnt=3.
REQ-035 The bench SHALL cover: fifo_full high for 5 cycles during the ch1 grant at beat 4 -> tready[1]=0 and no fifo_wr for those 5 cycles, grant held, beats 4..7 follow after full drops.
REQ-036 The bench SHALL cover: ch_en=4'b1010 with all channels valid -> only ch1 and ch3 are granted, alternating.
REQ-037 The bench SHALL cover: rst_n low for 1 cycle mid-burst on ch3 -> tready and fifo_wr 0 that cycle, word_cnt=0, and the next grant is to ch0 when valid.
REQ-038 The bench SHALL cover: word_cnt preloaded by force to 0xFFFFFFFE followed by 3 writes -> word_cnt=1.
